// File: rtl/button_reader.sv
// Debounced user-button front end: two-flop synchronizer, four-state
// debounce FSM, press/release/long-press pulses and a 5-bit LED counter.
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int LONG_CYCLES     = 6000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic BTN,
  output logic pressed,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic REL_LVL = ACTIVE_LOW;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);
  localparam logic [HW-1:0] HC_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HC_ONE  = HW'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t state, state_n;

  logic          sync1, sync2;
  logic          p;
  logic [DW-1:0] dbc, dbc_n;
  logic [HW-1:0] hc, hc_n;
  logic          long_done, long_done_n;
  logic [4:0]    count, count_n;
  logic          press_n, release_n, long_n, pressed_n;

  // p is the pressed level regardless of pin polarity
  assign p = sync2 ^ REL_LVL;

  always_comb begin
    state_n     = state;
    dbc_n       = dbc;
    hc_n        = hc;
    long_done_n = long_done;
    press_n     = 1'b0;
    release_n   = 1'b0;
    long_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (p) begin
          state_n = PRESS_WAIT;
          dbc_n   = DB_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_n = IDLE;
        end else if (dbc == DB_LAST) begin
          state_n     = PRESSED;
          press_n     = 1'b1;
          hc_n        = '0;
          long_done_n = 1'b0;
        end else begin
          dbc_n = dbc + DB_ONE;
        end
      end
      PRESSED: begin
        if (!p) begin
          state_n = RELEASE_WAIT;
          dbc_n   = DB_ONE;
        end else if (hc == HC_LAST && !long_done) begin
          long_n      = 1'b1;
          long_done_n = 1'b1;
        end else if (!long_done) begin
          hc_n = hc + HC_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_n = PRESSED;
        end else if (dbc == DB_LAST) begin
          state_n   = IDLE;
          release_n = 1'b1;
        end else begin
          dbc_n = dbc + DB_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    count_n = count;
    if (press_n) begin
      count_n = count + 5'd1;
    end else if (long_n) begin
      count_n = '0;
    end
  end

  assign pressed_n = (state_n == PRESSED) || (state_n == RELEASE_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1         <= REL_LVL;
      sync2         <= REL_LVL;
      state         <= IDLE;
      dbc           <= '0;
      hc            <= '0;
      long_done     <= 1'b0;
      count         <= '0;
      pressed       <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      sync1         <= BTN;
      sync2         <= sync1;
      state         <= state_n;
      dbc           <= dbc_n;
      hc            <= hc_n;
      long_done     <= long_done_n;
      count         <= count_n;
      pressed       <= pressed_n;
      press         <= press_n;
      release_pulse <= release_n;
      long_press    <= long_n;
    end
  end

  assign LED0 = count[0];
  assign LED1 = count[1];
  assign LED2 = count[2];
  assign LED3 = count[3];
  assign LED4 = count[4];

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
module tb_button_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic BTN = 1'b1;
  logic pressed, press, release_pulse, long_press;
  logic LED0, LED1, LED2, LED3, LED4;

  int checks = 0;
  int failures = 0;

  button_reader #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(16),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .BTN(BTN),
    .pressed(pressed),
    .press(press),
    .release_pulse(release_pulse),
    .long_press(long_press),
    .LED0(LED0),
    .LED1(LED1),
    .LED2(LED2),
    .LED3(LED3),
    .LED4(LED4)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] leds();
    return {LED4, LED3, LED2, LED1, LED0};
  endfunction

  function automatic logic [8:0] outs();
    return {pressed, press, release_pulse, long_press, leds()};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rel_cnt, lp_cnt, pr_cnt;

  initial begin
    // reset, then idle with button released
    BTN = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_outs", 32'(outs()), 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_outs", 32'(outs()), 0);
    end

    // clean press, held 10 cycles; tick e ends just after edge e
    BTN = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk("press_pulse", 32'(press), 32'(e == 5));
      chk("press_level", 32'(pressed), 32'(e >= 5));
      chk("press_led", 32'(leds()), (e >= 5) ? 1 : 0);
      chk("press_nolong", 32'(long_press), 0);
    end
    BTN = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk("rel_pulse", 32'(release_pulse), 32'(e == 5));
      chk("rel_level", 32'(pressed), 32'(e < 5));
      chk("rel_nopress", 32'(press), 0);
    end
    chk("rel_led", 32'(leds()), 1);

    // bounce shorter than the debounce window
    BTN = 1'b0;
    repeat (3) tick();
    BTN = 1'b1;
    pr_cnt = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      pr_cnt += int'(press);
      chk("bounce_level", 32'(pressed), 0);
    end
    chk("bounce_nopress", 32'(pr_cnt), 0);
    chk("bounce_led", 32'(leds()), 1);

    // press, then a one-cycle glitch while held
    BTN = 1'b0;
    repeat (8) tick();
    chk("glitch_pre_led", 32'(leds()), 2);
    BTN = 1'b1;
    tick();
    BTN = 1'b0;
    pr_cnt = 0;
    rel_cnt = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      pr_cnt += int'(press);
      rel_cnt += int'(release_pulse);
      chk("glitch_level", 32'(pressed), 1);
    end
    chk("glitch_nopress", 32'(pr_cnt), 0);
    chk("glitch_norel", 32'(rel_cnt), 0);
    BTN = 1'b1;
    rel_cnt = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      rel_cnt += int'(release_pulse);
    end
    chk("glitch_rel_once", 32'(rel_cnt), 1);
    chk("glitch_led", 32'(leds()), 2);

    // long hold: press at edge 5, long_press at edge 21
    BTN = 1'b0;
    lp_cnt = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      lp_cnt += int'(long_press);
      chk("long_press_pulse", 32'(press), 32'(e == 5));
      chk("long_pulse", 32'(long_press), 32'(e == 21));
      chk("long_led", 32'(leds()), (e < 5) ? 2 : (e < 21) ? 3 : 0);
    end
    BTN = 1'b1;
    rel_cnt = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      rel_cnt += int'(release_pulse);
      lp_cnt += int'(long_press);
    end
    chk("long_once", 32'(lp_cnt), 1);
    chk("long_rel", 32'(rel_cnt), 1);
    chk("long_led_end", 32'(leds()), 0);

    // 33 short presses wrap the counter to 1
    pr_cnt = 0;
    rel_cnt = 0;
    for (int n = 0; n < 33; n++) begin
      BTN = 1'b0;
      for (int e = 0; e < 8; e++) begin
        tick();
        pr_cnt += int'(press);
        rel_cnt += int'(release_pulse);
      end
      BTN = 1'b1;
      for (int e = 0; e < 8; e++) begin
        tick();
        pr_cnt += int'(press);
        rel_cnt += int'(release_pulse);
      end
      if (n == 30) chk("wrap_led_31", 32'(leds()), 31);
    end
    chk("wrap_presses", 32'(pr_cnt), 33);
    chk("wrap_releases", 32'(rel_cnt), 33);
    chk("wrap_led", 32'(leds()), 1);

    // async reset mid-debounce, button kept held
    BTN = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outs", 32'(outs()), 0);
    tick();
    chk("rst_hold_outs", 32'(outs()), 0);
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk("rst_press_pulse", 32'(press), 32'(e == 5));
      chk("rst_press_level", 32'(pressed), 32'(e >= 5));
      chk("rst_led", 32'(leds()), (e >= 5) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
